// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {S_START, S_FETCH, S_SQUASH, S_HOLD} state_e;

  localparam int unsigned PC_INC     = 4;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 26;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory handshake, decode handshake and execute redirect.
interface instr_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_ack;

  logic [DATA_W-1:0] instr;
  logic [7:0]        opcode;
  logic [ADDR_W-1:0] instr_pc4;
  logic              instr_valid;
  logic              instr_ready;

  logic              redir_valid;
  logic              jump;
  logic              branch_eq;
  logic              branch_not_eq;
  logic              zero;
  logic [ADDR_W-1:0] ex_pc4;
  logic [15:0]       ex_imm;
  logic [25:0]       ex_target;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_pc4, instr_valid,
    input  imem_rdata, imem_ack, instr_ready,
    input  redir_valid, jump, branch_eq, branch_not_eq, zero, ex_pc4, ex_imm, ex_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_pc4, instr_valid,
    output imem_rdata, imem_ack, instr_ready,
    output redir_valid, jump, branch_eq, branch_not_eq, zero, ex_pc4, ex_imm, ex_target
  );
endinterface

// File: rtl/instr_fetch_next_pc_calc.sv
// Combinational redirect resolver: decides whether execute redirects fetch and where to.
module next_pc_calc #(
  parameter int ADDR_W = 32
) (
  input  logic              redir_valid_i,
  input  logic              jump_i,
  input  logic              branch_eq_i,
  input  logic              branch_not_eq_i,
  input  logic              zero_i,
  input  logic [ADDR_W-1:0] ex_pc4_i,
  input  logic [15:0]       ex_imm_i,
  input  logic [25:0]       ex_target_i,
  output logic              taken_o,
  output logic [ADDR_W-1:0] target_o
);
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;

  assign br_off  = {{(ADDR_W-18){ex_imm_i[15]}}, ex_imm_i, 2'b00};
  assign br_tgt  = ex_pc4_i + br_off;
  assign j_tgt   = {ex_pc4_i[ADDR_W-1:28], ex_target_i, 2'b00};

  assign taken_o  = redir_valid_i &
                    (jump_i | (branch_eq_i & zero_i) | (branch_not_eq_i & ~zero_i));
  // Jump wins when the decoder flags both a jump and a branch.
  assign target_o = jump_i ? j_tgt : br_tgt;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches one word at a time and holds it for decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              req_q, req_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_seq;

  assign pc_seq = pc_q + ADDR_W'(PC_INC);

  next_pc_calc #(.ADDR_W(ADDR_W)) u_npc (
    .redir_valid_i   (bus.redir_valid),
    .jump_i          (bus.jump),
    .branch_eq_i     (bus.branch_eq),
    .branch_not_eq_i (bus.branch_not_eq),
    .zero_i          (bus.zero),
    .ex_pc4_i        (bus.ex_pc4),
    .ex_imm_i        (bus.ex_imm),
    .ex_target_i     (bus.ex_target),
    .taken_o         (taken),
    .target_o        (target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_START;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      pc4_q   <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      pc4_q   <= pc4_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    pc4_d   = pc4_q;
    req_d   = req_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    unique case (state_q)
      S_START: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      S_FETCH: begin
        if (!req_q) begin
          // Re-issue after the one-cycle gap that follows a discarded response.
          req_d  = 1'b1;
          pc_d   = taken ? target : pc_q;
          addr_d = taken ? target : pc_q;
        end else if (bus.imem_ack) begin
          req_d = 1'b0;
          if (taken) begin
            pc_d = target;
          end else begin
            instr_d = bus.imem_rdata;
            pc4_d   = pc_seq;
            vld_d   = 1'b1;
            state_d = S_HOLD;
          end
        end else if (taken) begin
          pc_d    = target;
          state_d = S_SQUASH;
        end
      end
      S_SQUASH: begin
        if (taken) pc_d = target;
        if (bus.imem_ack) begin
          req_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (taken || bus.instr_ready) begin
          vld_d   = 1'b0;
          req_d   = 1'b1;
          pc_d    = taken ? target : pc_seq;
          addr_d  = taken ? target : pc_seq;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_START;
    endcase
  end

  always_comb begin
    bus.imem_req    = req_q;
    bus.imem_addr   = addr_q;
    bus.instr       = instr_q;
    bus.opcode      = {2'b00, instr_q[OPCODE_MSB:OPCODE_LSB]};
    bus.instr_pc4   = pc4_q;
    bus.instr_valid = vld_q;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the main control decoder.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Holds the fetched instruction for decode under a valid/ready handshake; decode receives opcode bits [31:26] zero-extended to 8 bits.
- Applies redirects from execute, computed from the decoder's jump/branch_eq/branch_not_eq outputs and the ALU zero flag.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width (byte address).
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request; held until imem_ack
- imem_addr  output  ADDR_W  fetch address; stable while imem_req=1
- imem_rdata  input  DATA_W  instruction data, valid when imem_ack=1
- imem_ack  input  1  one-cycle completion pulse, latency >=1 cycle after req
- instr  output  DATA_W  held instruction
- opcode  output  8  {2'b00, instr[31:26]}, feeds decoder input
- instr_pc4  output  ADDR_W  PC of held instruction + 4
- instr_valid  output  1  instr/opcode/instr_pc4 valid
- instr_ready  input  1  decode accepts the held instruction
- redir_valid  input  1  execute presents a resolved control-flow instruction this cycle
- jump, branch_eq, branch_not_eq  input  1 each  decoder outputs carried to execute
- zero  input  1  ALU zero flag
- ex_pc4  input  ADDR_W  PC+4 of the resolving instruction
- ex_imm  input  16  branch immediate
- ex_target  input  26  jump target field

Behaviour:
- One clock (clk); reset is asynchronous and active-high. All registers clear immediately on reset assertion, independent of clk.
- Reset values:
  - state=S_START, pc=RESET_PC
  - imem_req=0, imem_addr=RESET_PC
  - instr=0, opcode=0, instr_pc4=0, instr_valid=0
- Reset mid-fetch: any outstanding request is abandoned. The memory model must tolerate a dropped req.
- Redirect decision (combinational):
  - taken = redir_valid & (jump | (branch_eq & zero) | (branch_not_eq & ~zero)).
  - Branch target = ex_pc4 + (sign_extend(ex_imm) << 2), mod 2^ADDR_W; wrap is silent.
  - Jump target = {ex_pc4[ADDR_W-1:28], ex_target, 2'b00}.
  - jump has priority over branch when both are set.
- State machine (registered outputs):
  - S_START: imem_req=0. Next cycle -> S_FETCH.
  - S_FETCH: imem_req=1, imem_addr=pc.
    - ack & ~taken: instr<=imem_rdata, instr_pc4<=pc+4, instr_valid<=1 -> S_HOLD.
    - ack & taken: discard data, pc<=target -> S_FETCH; request deasserts for one cycle.
    - ~ack & taken: pc<=target -> S_SQUASH; imem_addr stays at the old address.
    - Otherwise hold.
  - S_SQUASH: imem_req=1 with the old address until ack; the returned data is discarded.
    - A further taken redirect overwrites pc (latest wins).
    - On ack -> S_FETCH with the new pc.
  - S_HOLD: instr_valid=1, imem_req=0.
    - taken: instr_valid<=0, pc<=target -> S_FETCH. Redirect beats acceptance.
    - instr_ready & ~taken: instr_valid<=0, pc<=pc+4 -> S_FETCH.
    - Otherwise hold all outputs stable.
- Throughput: at most one instruction per (memory latency + 2) cycles. No prefetch; no internal buffering beyond the one instruction register.
- redir_valid in S_START is ignored.
- Redirect targets are not alignment-checked.

Decomposition:
- Shared package fetch_pkg:
  - state enum {S_START, S_FETCH, S_SQUASH, S_HOLD}
  - PC_INC=4
  - OPCODE_MSB=31, OPCODE_LSB=26
- Sub-module next_pc_calc: purely combinational; computes taken and target from the redirect inputs. It is unit-tested standalone.

Test Plan:
1. Reset release, imem_ack 2 cycles after each req, instr_ready=1: fetch addresses 0x0, 0x4, 0x8; instr_valid pulses once per fetch. Instruction 0x35000000 gives opcode=0x0D and instr_pc4=0x4.
2. Backpressure: instr_ready=0 for 5 cycles in S_HOLD: instr, instr_valid and instr_pc4 stay stable and imem_req stays 0. Ready=1 -> next fetch at +4.
3. beq taken (branch_eq=1, zero=1, ex_pc4=0x100, ex_imm=0xFFFE) in S_HOLD: held instruction dropped, next imem_addr=0xF8.
4. bne with zero=1 (not taken): no redirect, sequential fetch continues. Jump with ex_pc4=0x40000010, ex_target=0x0000040 -> imem_addr=0x40000100.
5. Redirect while a fetch is outstanding (ack at latency 4): imem_addr holds the old address until ack; that data never reaches instr_valid; the next request uses the target.
6. Assert reset mid-S_FETCH with imem_req=1: imem_req, instr_valid and pc clear immediately without a clock edge; after release the first fetch is at RESET_PC.
